sha_msg_loader: RTL
===================

SHA_MSG_LOADER -- requirements
Module: sha_msg_loader

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on rdy (legal 2..3).
REQ-002 SHALL have parameter HDR_BYTES, default 80, meaning the header length in bytes (fixed 80; any other value is illegal).
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 start  input  1  level; begins a load when sampled high in IDLE.
REQ-006 data_in  input  8  header byte from host; valid when rdy rises.
REQ-007 rdy  input  1  host strobe, asynchronous to clk; rising edge means data_in is valid.
REQ-008 rq  output  1  byte request to host; high while waiting for a byte.
REQ-009 word_out  output  32  message word to the SHA-256 compressor.
REQ-010 word_valid  output  1  word_out is valid.
REQ-011 word_ready  input  1  compressor accepts word_out.
REQ-012 word_idx  output  4  index 0..15 of word_out within its 512-bit block.
REQ-013 block_last  output  1  high with word 15 of block 2 (message word 31).
REQ-014 busy  output  1  high from accepted start until the final word transfer.

Function
REQ-015 SHALL emit exactly 32 words (two 512-bit blocks) per load; words 0..19 from header bytes, then SHA-256 padding.
REQ-016 SHALL pack bytes big-endian: first byte of each group of 4 into word_out[31:24], last into [7:0].
REQ-017 Padding words SHALL be: w20=32'h80000000, w21..w30=32'h0, w31=32'h00000280 (640-bit length).
REQ-018 States SHALL be: IDLE, REQ, EMIT, PAD; IDLE->REQ on start; REQ->EMIT after 4th byte of a word; EMIT->REQ on transfer if fewer than 20 header words sent; EMIT->PAD on transfer of w19; PAD->IDLE on transfer of w31.
REQ-019 rdy SHALL pass through SYNC_STAGES flops followed by rising-edge detection; a byte is captured one cycle after the detected edge.
REQ-020 rq SHALL rise on entry to REQ and fall in the cycle the byte is captured; it SHALL NOT re-rise for the next byte until the host has driven rdy low (synchronized rdy low).
REQ-021 rdy edges outside REQ SHALL be ignored; no byte captured, no counter change.
REQ-022 A transfer SHALL occur when word_valid && word_ready; word_out, word_idx and block_last SHALL hold stable while word_valid is high without word_ready.
REQ-023 word_idx SHALL equal message word number mod 16 and wrap 15->0 between blocks.
REQ-024 start while busy SHALL be ignored; start high in the same cycle as the final transfer SHALL NOT begin a new load (the block returns to IDLE first).
REQ-025 Byte counter SHALL be 7 bits, saturating at HDR_BYTES; word counter 5 bits, 0..31, no wrap within a load.

Reset
REQ-026 On rst_n low, the block SHALL enter IDLE asynchronously, clearing counters and synchronizer flops; rq=0, word_valid=0, word_out=0, word_idx=0, block_last=0, busy=0.
REQ-027 Reset mid-load SHALL abandon the load; no partial words SHALL be emitted after release.

Configuration
REQ-028 Macro LOADER_NONCE_EN SHALL add input nonce[31:0]; when defined, only 76 bytes are requested and w19 = nonce verbatim, emitted directly after w18.
REQ-029 Without LOADER_NONCE_EN, there SHALL be no nonce port and all 80 bytes are requested from the host.

Structure
REQ-030 Shared package sha_pkg SHALL hold the loader state enum, PAD_WORD (32'h80000000), HDR_LEN_BITS (640), and WORDS_PER_BLOCK (16).
REQ-031 Sub-module sha_sync_edge (SYNC_STAGES-flop synchronizer plus rising-edge pulse) SHALL be instantiated for rdy.

Verification
REQ-032 Genesis header 0100...7C fed with word_ready=1 -> w0=32'h01000000, w19=32'h1DAC2B7C, w20=32'h80000000, w31=32'h00000280, block_last only on w31.
REQ-033 word_ready held low 5 cycles at w7 -> word_out/word_idx stable for the 5 cycles, no rq during the stall, no lost byte.
REQ-034 rdy pulse of 3 ns in IDLE and a second pulse while rq=0 -> byte and word counts unchanged.
REQ-035 rst_n low after byte 41 -> all outputs zero; a subsequent start restarts at byte 0 with w0 correct.
REQ-036 start pulsed at byte 10, and again in the cycle of the w31 transfer -> both ignored; busy=0 next cycle.
REQ-037 LOADER_NONCE_EN defined, nonce=32'hDEADBEEF -> exactly 76 rq pulses, w19=32'hDEADBEEF.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 header message loader: FSM states and padding constants.
package sha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EMIT = 2'd2,
        ST_PAD  = 2'd3
    } loader_state_e;

    localparam logic [31:0] PAD_WORD        = 32'h8000_0000;
    localparam int unsigned HDR_LEN_BITS    = 640;
    localparam int unsigned WORDS_PER_BLOCK = 16;
    localparam logic [4:0]  LAST_WORD       = 5'd31;

    // Padding content for message words 20..31 of an 80-byte message.
    function automatic logic [31:0] pad_word(input logic [4:0] idx);
        if (idx == 5'd20) begin
            return PAD_WORD;
        end else if (idx == LAST_WORD) begin
            return 32'(HDR_LEN_BITS);
        end
        return 32'h0;
    endfunction

endpackage

// File: rtl/sha_sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe, with a one-cycle rising-edge pulse.
module sha_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/sha_msg_loader.sv
// Loads an 80-byte header from a byte-wide async host and emits two padded SHA-256 blocks.
// Optional LOADER_NONCE_EN: only 76 bytes are requested and word 19 comes from i_nonce.
module sha_msg_loader
    import sha_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HDR_BYTES   = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_data_in,
    input  logic        i_rdy,
`ifdef LOADER_NONCE_EN
    input  logic [31:0] i_nonce,
`endif
    output logic        o_rq,
    output logic [31:0] o_word_out,
    output logic        o_word_valid,
    input  logic        i_word_ready,
    output logic [3:0]  o_word_idx,
    output logic        o_block_last,
    output logic        o_busy
);

`ifdef LOADER_NONCE_EN
    localparam int REQ_BYTES = HDR_BYTES - 4;
`else
    localparam int REQ_BYTES = HDR_BYTES;
`endif
    localparam logic [6:0] REQ_BYTES_C   = 7'(REQ_BYTES);
    localparam logic [4:0] LAST_REQ_WORD = 5'(REQ_BYTES / 4 - 1);

    loader_state_e r_state;
    logic [6:0]    r_bcnt;
    logic [4:0]    r_wcnt;
    logic [31:0]   r_word;
    logic          r_valid;
    logic          r_rq;
    logic          r_busy;
    logic          r_pend;
    logic          w_rdy_lvl;
    logic          w_rdy_rise;
    logic          w_xfer;

    sha_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rdy_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i_rdy),
        .o_level (w_rdy_lvl),
        .o_rise  (w_rdy_rise)
    );

    assign w_xfer = r_valid & i_word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bcnt  <= '0;
            r_wcnt  <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_rq    <= 1'b0;
            r_busy  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_REQ;
                        r_busy  <= 1'b1;
                        r_bcnt  <= '0;
                        r_wcnt  <= '0;
                        r_pend  <= 1'b0;
                        r_rq    <= ~w_rdy_lvl;
                    end
                end
                ST_REQ: begin
                    // Capture lands one cycle after the detected edge; rq drops on capture.
                    if (r_pend) begin
                        r_pend <= 1'b0;
                        r_rq   <= 1'b0;
                        r_word <= {r_word[23:0], i_data_in};
                        if (r_bcnt != REQ_BYTES_C) begin
                            r_bcnt <= r_bcnt + 7'd1;
                        end
                        if (r_bcnt[1:0] == 2'd3) begin
                            r_state <= ST_EMIT;
                            r_valid <= 1'b1;
                        end
                    end else if (w_rdy_rise && r_rq) begin
                        r_pend <= 1'b1;
                    end else if (!r_rq && !w_rdy_lvl) begin
                        r_rq <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (w_xfer) begin
                        r_wcnt <= r_wcnt + 5'd1;
                        if (r_wcnt < LAST_REQ_WORD) begin
                            r_state <= ST_REQ;
                            r_valid <= 1'b0;
                            r_rq    <= ~w_rdy_lvl;
`ifdef LOADER_NONCE_EN
                        end else if (r_wcnt == LAST_REQ_WORD) begin
                            r_word <= i_nonce;
`endif
                        end else begin
                            r_state <= ST_PAD;
                            r_word  <= PAD_WORD;
                        end
                    end
                end
                ST_PAD: begin
                    if (w_xfer) begin
                        if (r_wcnt == LAST_WORD) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_wcnt  <= '0;
                        end else begin
                            r_wcnt <= r_wcnt + 5'd1;
                            r_word <= pad_word(r_wcnt + 5'd1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rq         = r_rq;
    assign o_word_out   = r_word;
    assign o_word_valid = r_valid;
    assign o_word_idx   = r_wcnt[3:0];
    assign o_block_last = r_valid && (r_wcnt == LAST_WORD);
    assign o_busy       = r_busy;

endmodule
